// File: rtl/axi4_reg_cfg_sequencer.sv
// AXI4-Lite write-only master that replays a fixed (address, data) table into a register slave.
// One transaction in flight; stops on the first error response or timeout.
module axi4_reg_cfg_sequencer #(
    parameter int unsigned AXI_DATA_WIDTH_P = 32,
    parameter int unsigned AXI_ADDR_WIDTH_P = 16,
    parameter int unsigned NR_OF_WRITES_P   = 4,
    parameter int unsigned TIMEOUT_P        = 255,
    localparam int unsigned IdxW = (NR_OF_WRITES_P > 1) ? $clog2(NR_OF_WRITES_P) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [NR_OF_WRITES_P*AXI_ADDR_WIDTH_P-1:0] cfg_addr,
    input  logic [NR_OF_WRITES_P*AXI_DATA_WIDTH_P-1:0] cfg_data,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error,
    output logic [IdxW-1:0]                            err_index,
    output logic [AXI_ADDR_WIDTH_P-1:0]                awaddr,
    output logic                                       awvalid,
    input  logic                                       awready,
    output logic [AXI_DATA_WIDTH_P-1:0]                wdata,
    output logic [AXI_DATA_WIDTH_P/8-1:0]              wstrb,
    output logic                                       wvalid,
    input  logic                                       wready,
    input  logic [1:0]                                 bresp,
    input  logic                                       bvalid,
    output logic                                       bready
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_P + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp, StFin} state_e;

    state_e                      state_q, state_d;
    logic [IdxW-1:0]             index_q, index_d;
    logic [IdxW-1:0]             err_index_q, err_index_d;
    logic [TimerW-1:0]           timer_q, timer_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        bready_q, bready_d;
    logic [AXI_ADDR_WIDTH_P-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH_P-1:0] wdata_q, wdata_d;

    logic [IdxW-1:0] index_nxt;
    logic            timeout;
    logic            b_hs;
    logic            last_entry;

    assign index_nxt  = index_q + IdxW'(1);
    assign timeout    = (timer_q == TimerW'(TIMEOUT_P - 1));
    assign b_hs       = bvalid && bready_q;
    assign last_entry = (index_q == IdxW'(NR_OF_WRITES_P - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            index_q     <= '0;
            err_index_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            err_index_q <= err_index_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        err_index_d = err_index_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StIssue;
                    index_d   = '0;
                    timer_d   = '0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    awaddr_d  = cfg_addr[0 +: AXI_ADDR_WIDTH_P];
                    wdata_d   = cfg_data[0 +: AXI_DATA_WIDTH_P];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            StIssue: begin
                // bvalid is deliberately ignored here; a response before both handshakes is bogus.
                timer_d   = timer_q + TimerW'(1);
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (timeout) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bready_d    = 1'b0;
                    error_d     = 1'b1;
                    err_index_d = index_q;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end else if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                timer_d = timer_q + TimerW'(1);
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (bresp != 2'b00) begin
                        error_d     = 1'b1;
                        err_index_d = index_q;
                        busy_d      = 1'b0;
                        state_d     = StIdle;
                    end else if (last_entry) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StFin;
                    end else begin
                        index_d   = index_nxt;
                        timer_d   = '0;
                        awaddr_d  = cfg_addr[int'(index_nxt)*AXI_ADDR_WIDTH_P +: AXI_ADDR_WIDTH_P];
                        wdata_d   = cfg_data[int'(index_nxt)*AXI_DATA_WIDTH_P +: AXI_DATA_WIDTH_P];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StIssue;
                    end
                end else if (timeout) begin
                    bready_d    = 1'b0;
                    error_d     = 1'b1;
                    err_index_d = index_q;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            // done is high for this single cycle, so a start here is not sampled.
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy      = busy_q;
        done      = done_q;
        error     = error_q;
        err_index = err_index_q;
        awaddr    = awaddr_q;
        awvalid   = awvalid_q;
        wdata     = wdata_q;
        wstrb     = '1;
        wvalid    = wvalid_q;
        bready    = bready_q;
    end

endmodule
